// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin arbiter that shares the register-file write port
//               between the ALU and load write-back paths, with a busy
//               scoreboard for RAW hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs_a,
    input  logic [AW-1:0]   rs_b,
    output logic            hazard,
    output logic [NREG-1:0] busy_mask,
    output logic [7:0]      conflict_cnt
);

    localparam logic [7:0]    c_CNT_MAX = 8'hFF;
    localparam logic [AW-1:0] c_R0      = '0;

    typedef enum logic [0:0] {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e          r_last_grant;
    grant_e          w_next_grant;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_wa;
    logic [DW-1:0]   r_rf_wd;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [7:0]      r_conflict_cnt;

    logic            w_grant_alu;
    logic            w_grant_mem;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;
    logic            w_both_valid;

    // Grant: a lone requester wins; on contention the source that did not
    // win last time is served. No grants are issued while in reset.
    always_comb begin
        w_both_valid = alu_valid && mem_valid;
        w_grant_alu  = 1'b0;
        w_grant_mem  = 1'b0;
        if (!rst) begin
            w_grant_alu = alu_valid && (!mem_valid || (r_last_grant == GRANT_MEM));
            w_grant_mem = mem_valid && (!alu_valid || (r_last_grant == GRANT_ALU));
        end
        w_xfer       = w_grant_alu || w_grant_mem;
        w_next_grant = r_last_grant;
        w_sel_rd     = alu_rd;
        w_sel_data   = alu_data;
        if (w_grant_alu) begin
            w_next_grant = GRANT_ALU;
        end else if (w_grant_mem) begin
            w_next_grant = GRANT_MEM;
            w_sel_rd     = mem_rd;
            w_sel_data   = mem_data;
        end
    end

    // Scoreboard: clear on the edge the register file captures the write,
    // then set for the newly issued writer so a same-edge set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_we) begin
            w_busy_next[r_rf_wa] = 1'b0;
        end
        if (iss_valid && (iss_rd != c_R0)) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant   <= GRANT_MEM;
            r_rf_we        <= 1'b0;
            r_rf_wa        <= '0;
            r_rf_wd        <= '0;
            r_busy         <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_last_grant <= w_next_grant;
            r_busy       <= w_busy_next;
            if (w_xfer) begin
                r_rf_we <= (w_sel_rd != c_R0);
                r_rf_wa <= w_sel_rd;
                r_rf_wd <= w_sel_data;
            end else begin
                r_rf_we <= 1'b0;
            end
            if (w_both_valid && (r_conflict_cnt != c_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    assign alu_ready    = w_grant_alu;
    assign mem_ready    = w_grant_mem;
    assign rf_we        = r_rf_we;
    assign rf_wa        = r_rf_wa;
    assign rf_wd        = r_rf_wd;
    assign busy_mask    = r_busy;
    assign hazard       = r_busy[rs_a] | r_busy[rs_b];
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [DW-1:0]   mem_data;
    logic            mem_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   rs_a;
    logic [AW-1:0]   rs_b;
    logic            hazard;
    logic [NREG-1:0] busy_mask;
    logic [7:0]      conflict_cnt;

    int r_checks   = 0;
    int r_failures = 0;

    rf_wb_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .rs_a         (rs_a),
        .rs_b         (rs_b),
        .hazard       (hazard),
        .busy_mask    (busy_mask),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks = r_checks + 1;
        if (got !== exp) begin
            r_failures = r_failures + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are then driven/sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contention table: expected grant (1 = ALU) and write address per cycle.
    logic [5:0]    c_exp_alu = 6'b110101;   // bit i = cycle i
    logic [AW-1:0] c_exp_wa [6] = '{3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd4};

    initial begin
        int ai;
        int mi;
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'h11;
        mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 8'h25;
        iss_valid = 1'b0; iss_rd = '0; rs_a = '0; rs_b = '0;

        // Reset with both sources requesting
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        tick();
        tick();
        check("rst_rf_we", rf_we, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_cnt", conflict_cnt, 0);
        rst = 1'b0;

        // Contention: ALU rd 1..4, MEM rd 5..6, each held until accepted
        ai = 0; mi = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = (ai < 4);
            alu_rd    = 3'(ai + 1);
            alu_data  = 8'h11 + 8'(ai);
            mem_valid = (mi < 2);
            mem_rd    = 3'(mi + 5);
            mem_data  = 8'h25 + 8'(mi);
            #1;
            check($sformatf("cont_alu_ready%0d", c), alu_ready, c_exp_alu[c]);
            check($sformatf("cont_mem_ready%0d", c), mem_ready, !c_exp_alu[c]);
            if (alu_ready) ai++;
            if (mem_ready) mi++;
            tick();
            check($sformatf("cont_wa%0d", c), rf_wa, c_exp_wa[c]);
            check($sformatf("cont_we%0d", c), rf_we, 1);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("cont_cnt", conflict_cnt, 4);

        // Single ALU write rd=3, data 0x5A
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 8'h5A;
        #1;
        check("single_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("single_we", rf_we, 1);
        check("single_wa", rf_wa, 3);
        check("single_wd", rf_wd, 8'h5A);
        tick();
        check("idle_we", rf_we, 0);
        check("idle_wa_hold", rf_wa, 3);
        check("idle_wd_hold", rf_wd, 8'h5A);

        // Scoreboard set/clear on r2
        iss_valid = 1'b1; iss_rd = 3'd2;
        tick();
        iss_valid = 1'b0;
        rs_a = 3'd2; rs_b = 3'd0;
        #1;
        check("sb_busy_set", busy_mask, 8'h04);
        check("sb_hazard_set", hazard, 1);
        alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 8'h77;
        tick();
        alu_valid = 1'b0;
        check("sb_we_r2", rf_we, 1);
        check("sb_hazard_during_we", hazard, 1);
        tick();
        check("sb_busy_clr", busy_mask, 8'h00);
        check("sb_hazard_clr", hazard, 0);

        // Same-edge set and clear of r2: set wins
        alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 8'h78;
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 3'd2;
        tick();
        iss_valid = 1'b0;
        check("sb_set_wins", busy_mask, 8'h04);
        tick();
        check("sb_set_wins_hold", busy_mask, 8'h04);
        alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 8'h79;
        tick();
        alu_valid = 1'b0;
        tick();
        check("sb_final_clr", busy_mask, 8'h00);

        // r0 writes and issues
        iss_valid = 1'b1; iss_rd = 3'd5;
        tick();
        iss_rd = 3'd0;
        mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 8'h99;
        #1;
        check("r0_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0; iss_valid = 1'b0;
        check("r0_no_we", rf_we, 0);
        check("r0_busy", busy_mask, 8'h20);
        rs_a = 3'd0; rs_b = 3'd5;
        #1;
        check("r0_hazard_rsb", hazard, 1);
        rs_b = 3'd0;
        #1;
        check("r0_no_hazard", hazard, 0);

        // Saturation: 300 contention cycles on top of 4 earlier ones
        iss_valid = 1'b1; iss_rd = 3'd7;
        alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 8'h66;
        mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 8'h44;
        tick();
        iss_valid = 1'b0;
        for (int i = 1; i < 300; i++) tick();
        check("sat_cnt", conflict_cnt, 255);

        // Reset mid-stream with both sources still requesting
        rst = 1'b1;
        #1;
        check("mid_rst_alu_ready", alu_ready, 0);
        check("mid_rst_mem_ready", mem_ready, 0);
        tick();
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_wa", rf_wa, 0);
        check("mid_rst_wd", rf_wd, 0);
        check("mid_rst_busy", busy_mask, 0);
        check("mid_rst_cnt", conflict_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_first", alu_ready, 1);
        check("post_rst_mem_wait", mem_ready, 0);
        tick();
        check("post_rst_cnt", conflict_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
